// File: rtl/fir_tap_sequencer.sv
// Sequences FIR coefficients to an external MAC for each input sample, then
// scales and saturates the MAC result and holds it until downstream takes it.
module fir_tap_sequencer #(
    parameter int NTAPS  = 4,
    parameter int OSHIFT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               win_en,
    output logic signed [15:0] tap,
    output logic [7:0]         tapnum,
    input  logic               dsp_done,
    input  logic signed [31:0] dsp_output,
    input  logic               coef_we,
    input  logic [7:0]         coef_addr,
    input  logic signed [15:0] coef_data,
    output logic               y_valid,
    input  logic               y_ready,
    output logic signed [15:0] y,
    output logic               overrun
);

    localparam logic [7:0] TAP_DONE = 8'(NTAPS);
    localparam logic [7:0] TAP_LAST = 8'(NTAPS - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, RUN, WAIT, OUT} state_t;

    state_t             state_reg;
    logic signed [15:0] coef_reg [NTAPS];
    logic               coef_wr_ok;
    logic [7:0]         rd_idx;
    logic signed [15:0] coef_rd;
    logic signed [31:0] shifted;
    logic signed [15:0] y_sat;

    assign coef_wr_ok = (state_reg == IDLE) && coef_we && (coef_addr < TAP_DONE);

    // Coefficient for the tap presented next cycle: 0 when leaving SHIFT, tapnum+1 in RUN.
    always_comb begin
        rd_idx  = (state_reg == RUN) ? tapnum + 8'd1 : 8'd0;
        coef_rd = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (rd_idx == 8'(i)) begin
                coef_rd = coef_reg[i];
            end
        end
    end

    always_comb begin
        shifted = dsp_output >>> OSHIFT;
        if (shifted > 32'sd32767) begin
            y_sat = 16'sh7FFF;
        end else if (shifted < -32'sd32768) begin
            y_sat = 16'sh8000;
        end else begin
            y_sat = shifted[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_reg[i] <= '0;
            end
        end else if (coef_wr_ok) begin
            for (int i = 0; i < NTAPS; i++) begin
                if (coef_addr == 8'(i)) begin
                    coef_reg[i] <= coef_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            sample_ready <= 1'b1;
            win_en       <= 1'b0;
            tap          <= '0;
            tapnum       <= TAP_DONE;
            y_valid      <= 1'b0;
            y            <= '0;
            overrun      <= 1'b0;
        end else begin
            win_en <= 1'b0;
            // Strobes arriving while busy are lost; flag it until reset.
            if (sample_valid && state_reg != IDLE) begin
                overrun <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (sample_valid) begin
                        state_reg    <= SHIFT;
                        sample_ready <= 1'b0;
                        win_en       <= 1'b1;
                    end
                end
                SHIFT: begin
                    state_reg <= RUN;
                    tapnum    <= 8'd0;
                    tap       <= coef_rd;
                end
                RUN: begin
                    if (tapnum == TAP_LAST) begin
                        state_reg <= WAIT;
                        tapnum    <= TAP_DONE;
                    end else begin
                        tapnum <= tapnum + 8'd1;
                        tap    <= coef_rd;
                    end
                end
                WAIT: begin
                    if (dsp_done) begin
                        state_reg <= OUT;
                        y         <= y_sat;
                        y_valid   <= 1'b1;
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        state_reg    <= IDLE;
                        y_valid      <= 1'b0;
                        sample_ready <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    sample_ready <= 1'b1;
                    tapnum       <= TAP_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed and randomized checks of fir_tap_sequencer against a sample-timeline
// model that counts cycles since each accepted strobe.
module tb_fir_tap_sequencer;

    localparam int NTAPS  = 4;
    localparam int OSHIFT = 15;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               sample_valid = 1'b0;
    logic               sample_ready;
    logic               win_en;
    logic signed [15:0] tap;
    logic [7:0]         tapnum;
    logic               dsp_done = 1'b0;
    logic signed [31:0] dsp_output = '0;
    logic               coef_we = 1'b0;
    logic [7:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               y_valid;
    logic               y_ready = 1'b0;
    logic signed [15:0] y;
    logic               overrun;

    int n_pass = 0;
    int n_total = 0;
    int exp_taps [NTAPS];

    fir_tap_sequencer #(.NTAPS(NTAPS), .OSHIFT(OSHIFT)) dut (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .win_en(win_en), .tap(tap), .tapnum(tapnum),
        .dsp_done(dsp_done), .dsp_output(dsp_output),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .y_valid(y_valid), .y_ready(y_ready), .y(y), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    // Model: m_seq counts edges since acceptance (1 = window shift, 2.. = taps).
    bit m_busy = 0, m_yv = 0, m_over = 0;
    int m_seq = 0, m_y = 0, m_tap = 0;
    int m_coef [NTAPS] = '{default: 0};

    function automatic int sat(input int d);
        int v = d >>> OSHIFT;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset;
        m_busy = 0; m_yv = 0; m_over = 0; m_seq = 0; m_y = 0; m_tap = 0;
        for (int i = 0; i < NTAPS; i++) m_coef[i] = 0;
    endtask

    task automatic model_step;
        bit ob = m_busy;
        int os = m_seq;
        if (!ob && coef_we && int'(coef_addr) < NTAPS) m_coef[int'(coef_addr)] = int'(coef_data);
        if (ob && sample_valid) m_over = 1;
        if (!ob) begin
            if (sample_valid) begin m_busy = 1; m_seq = 1; end
        end else if (m_yv) begin
            if (y_ready) begin m_yv = 0; m_busy = 0; end
        end else if (os >= NTAPS + 2) begin
            if (dsp_done) begin m_yv = 1; m_y = sat(int'(dsp_output)); end
        end else begin
            m_seq = os + 1;
            if (m_seq >= 2 && m_seq <= NTAPS + 1) m_tap = m_coef[m_seq - 2];
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        int etn;
        etn = (m_busy && m_seq >= 2 && m_seq <= NTAPS + 1) ? m_seq - 2 : NTAPS;
        chk("sample_ready", 32'(sample_ready), 32'(!m_busy));
        chk("win_en", 32'(win_en), 32'(m_busy && m_seq == 1));
        chk("tapnum", 32'(tapnum), etn);
        chk("tap", tap, m_tap);
        chk("y_valid", 32'(y_valid), 32'(m_yv));
        chk("y", y, m_y);
        chk("overrun", 32'(overrun), 32'(m_over));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals;
        chk("rst_ready", 32'(sample_ready), 32'd1);
        chk("rst_win_en", 32'(win_en), 32'd0);
        chk("rst_tap", tap, 32'd0);
        chk("rst_tapnum", 32'(tapnum), NTAPS);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
    endtask

    task automatic run_sample(input logic [31:0] dout, input int exp_y, input bit inj_strobe,
                              input bit inj_we, input bit we_with_strobe, input bit reset_in_wait);
        sample_valid = 1'b1;
        if (we_with_strobe) begin coef_we = 1'b1; coef_addr = 8'd0; coef_data = 16'sd7; end
        tick();
        sample_valid = 1'b0; coef_we = 1'b0;
        chk("d_win_en", 32'(win_en), 32'd1);
        chk("d_tapnum_shift", 32'(tapnum), NTAPS);
        for (int i = 0; i < NTAPS; i++) begin
            if (i == 1 && inj_strobe) sample_valid = 1'b1;
            if (i == 1 && inj_we) begin coef_we = 1'b1; coef_addr = 8'd0; coef_data = 16'sd99; end
            tick();
            sample_valid = 1'b0; coef_we = 1'b0;
            chk("d_tapnum", 32'(tapnum), i);
            chk("d_tap", tap, exp_taps[i]);
            chk("d_win_low", 32'(win_en), 32'd0);
        end
        tick();
        chk("d_tapnum_done", 32'(tapnum), NTAPS);
        chk("d_busy", 32'(sample_ready), 32'd0);
        if (reset_in_wait) begin
            #2 reset_n = 1'b0;
            #1 chk_reset_vals();
            @(posedge clk);
            #1 reset_n = 1'b1;
            return;
        end
        dsp_output = dout; dsp_done = 1'b1;
        tick();
        dsp_done = 1'b0;
        chk("d_y_valid", 32'(y_valid), 32'd1);
        chk("d_y", y, exp_y);
        dsp_output = 32'h0010_0000; dsp_done = 1'b1;
        tick();
        dsp_done = 1'b0;
        chk("d_y_hold_valid", 32'(y_valid), 32'd1);
        chk("d_y_hold", y, exp_y);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        chk("d_y_cleared", 32'(y_valid), 32'd0);
        chk("d_idle", 32'(sample_ready), 32'd1);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < NTAPS; i++) begin
            coef_we = 1'b1; coef_addr = 8'(i); coef_data = 16'(i + 1);
            tick();
        end
        coef_we = 1'b0;

        exp_taps = '{1, 2, 3, 4};
        run_sample(32'h0001_8000, 3, 0, 0, 0, 0);
        $display("sample 1: y=%0d", y);
        run_sample(32'h7FFF_FFFF, 32767, 1, 1, 0, 0);
        chk("d_overrun_set", 32'(overrun), 32'd1);
        $display("sample 2: y=%0d overrun=%0d", y, overrun);
        coef_we = 1'b1; coef_addr = 8'(NTAPS); coef_data = 16'sd77;
        tick();
        coef_we = 1'b0;
        run_sample(32'h8000_0000, -32768, 0, 0, 0, 0);
        chk("d_overrun_sticky", 32'(overrun), 32'd1);
        $display("sample 3: y=%0d", y);
        run_sample(32'h0, 0, 0, 0, 0, 1);
        $display("sample 4: reset during wait");
        exp_taps = '{7, 0, 0, 0};
        run_sample(32'hFFFF_8000, -1, 0, 0, 1, 0);
        $display("sample 5: y=%0d", y);

        for (int c = 0; c < 3000; c++) begin
            sample_valid = ($urandom_range(0, 9) < 3);
            coef_we      = ($urandom_range(0, 9) < 2);
            coef_addr    = 8'($urandom_range(0, NTAPS + 1));
            coef_data    = 16'($urandom);
            dsp_done     = ($urandom_range(0, 9) < 3);
            y_ready      = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 3))
                0: dsp_output = 32'($urandom);
                1: dsp_output = 32'h7FFF_FFFF - 32'($urandom_range(0, 255));
                2: dsp_output = 32'h8000_0000 + 32'($urandom_range(0, 255));
                default: dsp_output = 32'($urandom_range(0, 1 << 24)) - 32'(1 << 23);
            endcase
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick();
            if (y_valid && y_ready) $display("random cycle %0d: y=%0d", c, y);
        end
        sample_valid = 1'b0; coef_we = 1'b0; dsp_done = 1'b0; y_ready = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
